// File: rtl/cache_line_serializer_if.sv
// Write-back line handshake on the cache side and beat handshake on the burst-memory side.
// slave = the serializer; master = whoever drives the cache line in and consumes the beats.
interface cache_line_serializer_if #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned BEAT_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [LINE_WIDTH-1:0] wb_data;
  logic                  wb_done;
  logic                  bmem_write;
  logic [ADDR_WIDTH-1:0] bmem_addr;
  logic [BEAT_WIDTH-1:0] bmem_wdata;
  logic                  bmem_ready;

  modport slave (
    input  wb_valid, wb_addr, wb_data, bmem_ready,
    output wb_ready, wb_done, bmem_write, bmem_addr, bmem_wdata
  );

  modport master (
    output wb_valid, wb_addr, wb_data, bmem_ready,
    input  wb_ready, wb_done, bmem_write, bmem_addr, bmem_wdata
  );
endinterface

// File: rtl/cache_line_serializer.sv
// Takes one dirty cacheline and streams it to burst memory as BEATS beats, lowest beat first.
// Every output is a register; a held beat stays put until memory accepts it.
module cache_line_serializer #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned BEAT_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  cache_line_serializer_if.slave bus
);

  localparam int unsigned BEATS      = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;

  typedef logic [BEATS-1:0][BEAT_WIDTH-1:0] line_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  line_t                 r_buf, w_buf_nxt;
  line_t                 w_line_in;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [BEAT_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                  r_write, w_write_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_ready, w_ready_nxt;

  assign w_line_in = line_t'(bus.wb_data);

  // Next-state and next-output logic; the beat for the next cycle is selected here.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_buf_nxt   = r_buf;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_write_nxt = r_write;
    w_done_nxt  = 1'b0;
    w_ready_nxt = r_ready;

    case (r_state)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        w_write_nxt = 1'b0;
        if (bus.wb_valid) begin
          w_state_nxt = S_BURST;
          w_buf_nxt   = w_line_in;
          w_addr_nxt  = bus.wb_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
          w_cnt_nxt   = '0;
          w_wdata_nxt = w_line_in[0];
          w_write_nxt = 1'b1;
          w_ready_nxt = 1'b0;
        end
      end
      S_BURST: begin
        w_ready_nxt = 1'b0;
        w_write_nxt = 1'b1;
        if (r_write && bus.bmem_ready) begin
          if (r_cnt == CNT_W'(BEATS - 1)) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = '0;
            w_write_nxt = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_wdata_nxt = r_buf[r_cnt + CNT_W'(1)];
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_write_nxt = 1'b0;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_write_nxt = 1'b0;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_write <= w_write_nxt;
      r_done  <= w_done_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Line buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    r_buf <= w_buf_nxt;
  end

  assign bus.wb_ready   = r_ready;
  assign bus.wb_done    = r_done;
  assign bus.bmem_write = r_write;
  assign bus.bmem_addr  = r_addr;
  assign bus.bmem_wdata = r_wdata;

endmodule
